menu_controller: RTL and testbench
==================================

# menu_controller

Button-driven settings controller for the greenhouse VGA menu. Owns the menu cursor (`state`) and every user-editable value: temperature and humidity setpoints, the wall-clock time and the sunrise time. It advances the wall-clock on a once-per-minute tick. All of its outputs feed the menu display stage directly, and the setpoints also go to the climate logic.

## Interface

**Parameters**
- `TEMP_MIN`, default 40: lowest temperature setpoint, °F binary.
- `TEMP_MAX`, default 110: highest temperature setpoint, °F binary.
- `TEMP_DEFAULT`, default 72: temperature setpoint after reset.
- `HUM_MAX`, default 100: highest humidity setpoint, %. The minimum is 0.
- `HUM_DEFAULT`, default 50: humidity setpoint after reset.
- `SUNRISE_DEFAULT_H`, default 6: sunrise hour after reset.
- `HOLD_CYCLES`, default 12_500_000: clocks a button must be held before auto-repeat starts.
- `REPEAT_CYCLES`, default 2_500_000: clocks between auto-repeat steps.

**Ports**
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `btn_left` input 1: debounced level, moves the cursor left.
- `btn_right` input 1: debounced level, moves the cursor right.
- `btn_up` input 1: debounced level, increments the selected field.
- `btn_down` input 1: debounced level, decrements the selected field.
- `min_tick` input 1: one-cycle pulse, once per minute.
- `state` output 4: cursor position.
  - 0 = temp, 1 = hum, 2 = time hours, 3 = time minutes, 4 = sunrise hours, 5 = sunrise minutes.
- `set_temp` output 12: temperature setpoint, binary °F.
- `set_hum` output 8: humidity setpoint, binary %.
- `time_hours` output 5: wall-clock hours, 0–23.
- `time_minutes` output 6: wall-clock minutes, 0–59.
- `sunrise_hours` output 5: sunrise hours, 0–23.
- `sunrise_minutes` output 6: sunrise minutes, 0–59.
- `changed` output 1: one-cycle pulse when any value changes because of a button. It does not pulse for `min_tick`.

## Operation

**Reset values**
- `state` = 0, `set_temp` = TEMP_DEFAULT, `set_hum` = HUM_DEFAULT.
- `time_hours` = 0, `time_minutes` = 0.
- `sunrise_hours` = SUNRISE_DEFAULT_H, `sunrise_minutes` = 0.
- `changed` = 0.
- All button history registers clear to 0.

**Button sampling**
- Each button is registered once.
- A press event is the registered level high while the previous registered level was low (rising edge).
- A button that is high when reset releases generates no event until it goes low and then high again.

**Cursor FSM**
- Six states, 0 to 5.
- Right: state+1, wrapping 5→0.
- Left: state−1, wrapping 0→5.
- Left and right events in the same cycle: both are ignored.

**Edit, applied to the field selected by the current `state`**
- Temp: saturates at TEMP_MIN and TEMP_MAX; no wrap.
- Hum: saturates at 0 and HUM_MAX.
- Hours fields: wrap 23↔0.
- Minutes fields: wrap 59↔0, with no carry into hours.
- Up and down events in the same cycle: both are ignored.
- A navigation event (left or right) in the same cycle as an edit event: navigation is applied and the edit is dropped.
- `changed` pulses only when the value actually changes. A saturated press gives no pulse.

**Minute tick**
- `time_minutes` increments.
- 59→0 carries into `time_hours`.
- 23:59 → 00:00.
- If a button edit to `time_hours` or `time_minutes` is applied in the same cycle, the edit wins and the tick is dropped.
- A tick coinciding with an edit to any other field is applied normally.

**Reset mid-operation**
- All outputs return to their reset values immediately, because reset is asynchronous.
- A button held through reset is treated as described under button sampling.

## Timing

- Button level rises before clock edge k: the registered output updates at edge k+1, i.e. two-edge latency. `changed` is high for the cycle following edge k+1.
- `min_tick` high at edge k: the time registers update at edge k.
- All outputs are registered. There is no combinational path from any input to any output.
- Each press yields exactly one step, regardless of how long the button is held, unless auto-repeat is compiled in.

## Configuration

- Macro: `MENU_AUTOREPEAT_EN`.
- When defined:
  - `btn_up` or `btn_down` held continuously for HOLD_CYCLES after its press event generates an extra edit event.
  - It then generates a further edit event every REPEAT_CYCLES while still held.
  - The repeat counter clears on release, on a cursor change, and on reset.
  - Saturation and wrap rules apply to each repeat step exactly as to a press.
  - Left and right never repeat.
- When undefined: no repeat counter is present, and one press gives exactly one step.

## Structure

- Package `menu_pkg`:
  - State encodings: `MENU_TEMP`, `MENU_HUM`, `MENU_TIME_H`, `MENU_TIME_M`, `MENU_SUN_H`, `MENU_SUN_M`, `MENU_LAST` = 5.
  - Limits: `HOURS_MAX` = 23, `MINUTES_MAX` = 59.
- One sub-module, `button_event`:
  - Per-button register, edge detect, and the optional repeat counter.
  - Four instances.
- Wrap and saturate arithmetic live inline in the top level.

## Test plan

1. Reset release → `state`=0, temp=72, hum=50, time 00:00, sunrise 06:00, `changed`=0.
2. Five right presses, then one more → `state` goes 1..5, then wraps to 0. One left press from 0 → 5. Left and right pressed together → `state` unchanged.
3. `state`=0, temp=110, up press → temp stays 110 and `changed` stays 0. Down press → temp=109, `changed` pulses one cycle, two edges after the button rises.
4. `state`=3, minutes=59, hours=7, up press → minutes=0, hours=7. Then `min_tick` at time 23:59 → 00:00.
5. `state`=2 with an up press and `min_tick` landing in the same cycle → hours+1, minutes unchanged (tick dropped). Repeat the same coincidence with `state`=1 → hum+1 and the tick is applied.
6. Compiled with `MENU_AUTOREPEAT_EN`, HOLD=10, REPEAT=4, `state`=1, hum=50, up held 30 cycles → hum=56 (1 press step + 5 repeat steps). Same stimulus compiled without the macro → hum=51.

Source files
------------

// File: rtl/menu_pkg.sv
// menu_pkg: cursor encodings, clock-field limits and the wrap helper shared by the menu controller.
package menu_pkg;

    typedef enum logic [3:0] {
        MENU_TEMP   = 4'd0,
        MENU_HUM    = 4'd1,
        MENU_TIME_H = 4'd2,
        MENU_TIME_M = 4'd3,
        MENU_SUN_H  = 4'd4,
        MENU_SUN_M  = 4'd5
    } menu_state_e;

    localparam menu_state_e MENU_LAST = MENU_SUN_M;
    localparam logic [5:0] HOURS_MAX   = 6'd23;
    localparam logic [5:0] MINUTES_MAX = 6'd59;

    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max, input logic up);
        return up ? ((v == max) ? 6'd0 : v + 6'd1) : ((v == 6'd0) ? max : v - 6'd1);
    endfunction

endpackage

// File: rtl/menu_controller_button_event.sv
// button_event: registers one button, detects armed rising edges and, with MENU_AUTOREPEAT_EN, emits hold-repeat events.
module button_event
    import menu_pkg::*;
`ifdef MENU_AUTOREPEAT_EN
#(
    parameter bit          REPEAT_EN = 1'b0,
    parameter int unsigned HOLD      = 12_500_000,
    parameter int unsigned REPEAT    = 2_500_000
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
`ifdef MENU_AUTOREPEAT_EN
    input  logic clr_i,
`endif
    output logic evt_o
);

    logic btn_q, prev_q, arm_q, press;

    // arm_q stays low until the raw button is seen low, so a button held through reset is ignored
    assign press = btn_q & ~prev_q & arm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q  <= 1'b0;
            prev_q <= 1'b0;
            arm_q  <= 1'b0;
        end else begin
            btn_q  <= btn_i;
            prev_q <= btn_q;
            arm_q  <= arm_q | ~btn_i;
        end
    end

`ifdef MENU_AUTOREPEAT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        run_q, run_d, rep_q, rep_d, fire;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        rep_d = rep_q;
        fire  = 1'b0;
        if (!REPEAT_EN || clr_i || !btn_q) begin
            cnt_d = 32'd0;
            run_d = 1'b0;
            rep_d = 1'b0;
        end else if (press) begin
            cnt_d = 32'd1;
            run_d = 1'b1;
            rep_d = 1'b0;
        end else if (run_q) begin
            if (cnt_q == (rep_q ? REPEAT : HOLD)) begin
                fire  = 1'b1;
                cnt_d = 32'd1;
                rep_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 32'd0;
            run_q <= 1'b0;
            rep_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
            rep_q <= rep_d;
        end
    end

    assign evt_o = press | fire;
`else
    assign evt_o = press;
`endif

endmodule

// File: rtl/menu_controller.sv
// menu_controller: button-driven cursor and setpoint/clock editor with minute-tick timekeeping.
// Optional hold-to-repeat on up/down is enabled by defining MENU_AUTOREPEAT_EN.
module menu_controller
    import menu_pkg::*;
#(
    parameter int TEMP_MIN          = 40,
    parameter int TEMP_MAX          = 110,
    parameter int TEMP_DEFAULT      = 72,
    parameter int HUM_MAX           = 100,
    parameter int HUM_DEFAULT       = 50,
    parameter int SUNRISE_DEFAULT_H = 6,
    parameter int HOLD_CYCLES       = 12_500_000,
    parameter int REPEAT_CYCLES     = 2_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        min_tick,
    output logic [3:0]  state,
    output logic [11:0] set_temp,
    output logic [7:0]  set_hum,
    output logic [4:0]  time_hours,
    output logic [5:0]  time_minutes,
    output logic [4:0]  sunrise_hours,
    output logic [5:0]  sunrise_minutes,
    output logic        changed
);

    logic [3:0]  btns, evs;
    logic        ev_l, ev_r, ev_u, ev_d, nav, move, edit, time_edit, tick_go;
    menu_state_e state_q, state_d;
    logic [11:0] temp_q, temp_d;
    logic [7:0]  hum_q, hum_d;
    logic [4:0]  hr_q, hr_d, sh_q, sh_d;
    logic [5:0]  mn_q, mn_d, sm_q, sm_d, sel_v, sel_max, wv;
    logic        changed_q, changed_d;

    assign btns = {btn_down, btn_up, btn_right, btn_left};
    assign {ev_d, ev_u, ev_r, ev_l} = evs;

    for (genvar g = 0; g < 4; g++) begin : g_btn
        button_event
`ifdef MENU_AUTOREPEAT_EN
        #(
            .REPEAT_EN (g >= 2),
            .HOLD      (HOLD_CYCLES),
            .REPEAT    (REPEAT_CYCLES)
        )
`endif
        u_btn (
            .clk   (clk),
            .rst   (rst),
            .btn_i (btns[g]),
`ifdef MENU_AUTOREPEAT_EN
            .clr_i ((g >= 2) ? move : 1'b0),
`endif
            .evt_o (evs[g])
        );
    end

    // navigation of any kind swallows a same-cycle edit; opposing pairs cancel
    assign nav       = ev_l | ev_r;
    assign move      = ev_l ^ ev_r;
    assign edit      = ~nav & (ev_u ^ ev_d);
    assign time_edit = edit & (state_q == MENU_TIME_H || state_q == MENU_TIME_M);
    assign tick_go   = min_tick & ~time_edit;

    assign sel_v   = (state_q == MENU_TIME_H) ? {1'b0, hr_q} :
                     (state_q == MENU_TIME_M) ? mn_q :
                     (state_q == MENU_SUN_H)  ? {1'b0, sh_q} : sm_q;
    assign sel_max = (state_q == MENU_TIME_H || state_q == MENU_SUN_H) ? HOURS_MAX : MINUTES_MAX;
    assign wv      = wrap_step(sel_v, sel_max, ev_u);

    always_comb begin
        state_d = !move ? state_q :
                  ev_r ? ((state_q == MENU_LAST) ? MENU_TEMP : menu_state_e'(state_q + 4'd1)) :
                         ((state_q == MENU_TEMP) ? MENU_LAST : menu_state_e'(state_q - 4'd1));
        temp_d  = !(edit && state_q == MENU_TEMP) ? temp_q :
                  ev_u ? ((temp_q < 12'(TEMP_MAX)) ? temp_q + 12'd1 : temp_q) :
                         ((temp_q > 12'(TEMP_MIN)) ? temp_q - 12'd1 : temp_q);
        hum_d   = !(edit && state_q == MENU_HUM) ? hum_q :
                  ev_u ? ((hum_q < 8'(HUM_MAX)) ? hum_q + 8'd1 : hum_q) :
                         ((hum_q != 8'd0) ? hum_q - 8'd1 : hum_q);
        mn_d    = (edit && state_q == MENU_TIME_M) ? wv :
                  tick_go ? wrap_step(mn_q, MINUTES_MAX, 1'b1) : mn_q;
        hr_d    = (edit && state_q == MENU_TIME_H) ? wv[4:0] :
                  (tick_go && mn_q == MINUTES_MAX) ? ((hr_q == HOURS_MAX[4:0]) ? 5'd0 : hr_q + 5'd1) : hr_q;
        sh_d    = (edit && state_q == MENU_SUN_H) ? wv[4:0] : sh_q;
        sm_d    = (edit && state_q == MENU_SUN_M) ? wv : sm_q;
        // time edits always move the value and the tick is dropped then, so any time change is button-driven
        changed_d = edit & (({temp_d, hum_d, sh_d, sm_d} != {temp_q, hum_q, sh_q, sm_q}) | time_edit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MENU_TEMP;
            temp_q    <= 12'(TEMP_DEFAULT);
            hum_q     <= 8'(HUM_DEFAULT);
            hr_q      <= 5'd0;
            mn_q      <= 6'd0;
            sh_q      <= 5'(SUNRISE_DEFAULT_H);
            sm_q      <= 6'd0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            temp_q    <= temp_d;
            hum_q     <= hum_d;
            hr_q      <= hr_d;
            mn_q      <= mn_d;
            sh_q      <= sh_d;
            sm_q      <= sm_d;
            changed_q <= changed_d;
        end
    end

    assign state           = state_q;
    assign set_temp        = temp_q;
    assign set_hum         = hum_q;
    assign time_hours      = hr_q;
    assign time_minutes    = mn_q;
    assign sunrise_hours   = sh_q;
    assign sunrise_minutes = sm_q;
    assign changed         = changed_q;

endmodule

// File: tb/tb_menu_controller.sv
// tb_menu_controller: directed tests of cursor, edits, minute tick, async reset and optional auto-repeat.
module tb_menu_controller;

    logic        clk = 1'b0, rst = 1'b1;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, min_tick = 1'b0;
    logic [3:0]  state;
    logic [11:0] set_temp;
    logic [7:0]  set_hum;
    logic [4:0]  time_hours, sunrise_hours;
    logic [5:0]  time_minutes, sunrise_minutes;
    logic        changed;
    int          vecs = 0, errs = 0;

    menu_controller #(.HOLD_CYCLES(10), .REPEAT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
        .btn_down(btn_down), .min_tick(min_tick), .state(state), .set_temp(set_temp),
        .set_hum(set_hum), .time_hours(time_hours), .time_minutes(time_minutes),
        .sunrise_hours(sunrise_hours), .sunrise_minutes(sunrise_minutes), .changed(changed)
    );

    always #5 clk = ~clk;

    // c1: changed one cycle after the button rises; c2: changed after the second edge
    task automatic press(input logic l, r, u, d, tk, output logic c1, output logic c2);
        @(negedge clk);
        {btn_left, btn_right, btn_up, btn_down} = {l, r, u, d};
        @(negedge clk);
        c1 = changed;
        min_tick = tk;
        @(negedge clk);
        c2 = changed;
        {btn_left, btn_right, btn_up, btn_down, min_tick} = 5'b0;
        @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        min_tick = 1'b1;
        @(negedge clk);
        min_tick = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vecs++; if (state !== 4'd0) begin errs++; $display("FAIL reset_state: got %0d want 0", state); end
        vecs++; if (set_temp !== 12'd72) begin errs++; $display("FAIL reset_temp: got %0d want 72", set_temp); end
        vecs++; if (set_hum !== 8'd50) begin errs++; $display("FAIL reset_hum: got %0d want 50", set_hum); end
        vecs++; if ({time_hours, time_minutes} !== {5'd0, 6'd0}) begin errs++; $display("FAIL reset_time: got %0d:%0d want 0:0", time_hours, time_minutes); end
        vecs++; if ({sunrise_hours, sunrise_minutes} !== {5'd6, 6'd0}) begin errs++; $display("FAIL reset_sunrise: got %0d:%0d want 6:0", sunrise_hours, sunrise_minutes); end
        vecs++; if (changed !== 1'b0) begin errs++; $display("FAIL reset_changed: got %0d want 0", changed); end
    endtask

    task automatic test_nav();
        logic c1, c2;
        for (int i = 1; i <= 6; i++) begin
            press(0, 1, 0, 0, 0, c1, c2);
            vecs++; if (state !== 4'(i % 6)) begin errs++; $display("FAIL nav_right%0d: got %0d want %0d", i, state, i % 6); end
        end
        vecs++; if (c2 !== 1'b0) begin errs++; $display("FAIL nav_changed: got %0d want 0", c2); end
        press(1, 0, 0, 0, 0, c1, c2);
        vecs++; if (state !== 4'd5) begin errs++; $display("FAIL nav_left_wrap: got %0d want 5", state); end
        press(1, 1, 0, 0, 0, c1, c2);
        vecs++; if (state !== 4'd5) begin errs++; $display("FAIL nav_both: got %0d want 5", state); end
        press(0, 1, 0, 0, 0, c1, c2);
        vecs++; if (state !== 4'd0) begin errs++; $display("FAIL nav_back0: got %0d want 0", state); end
    endtask

    task automatic test_temp_sat();
        logic c1, c2;
        repeat (38) press(0, 0, 1, 0, 0, c1, c2);
        vecs++; if (set_temp !== 12'd110) begin errs++; $display("FAIL temp_to_max: got %0d want 110", set_temp); end
        press(0, 0, 1, 0, 0, c1, c2);
        vecs++; if (set_temp !== 12'd110) begin errs++; $display("FAIL temp_sat: got %0d want 110", set_temp); end
        vecs++; if ({c1, c2} !== 2'b00) begin errs++; $display("FAIL temp_sat_changed: got %b want 00", {c1, c2}); end
        press(0, 0, 0, 1, 0, c1, c2);
        vecs++; if (set_temp !== 12'd109) begin errs++; $display("FAIL temp_down: got %0d want 109", set_temp); end
        vecs++; if ({c1, c2} !== 2'b01) begin errs++; $display("FAIL temp_down_changed: got %b want 01", {c1, c2}); end
        vecs++; if (changed !== 1'b0) begin errs++; $display("FAIL changed_one_cycle: got %0d want 0", changed); end
        press(0, 0, 1, 1, 0, c1, c2);
        vecs++; if (set_temp !== 12'd109) begin errs++; $display("FAIL temp_up_down: got %0d want 109", set_temp); end
        press(0, 1, 1, 0, 0, c1, c2);
        vecs++; if ({state, set_temp} !== {4'd1, 12'd109}) begin errs++; $display("FAIL nav_over_edit: got %0d/%0d want 1/109", state, set_temp); end
        press(1, 0, 0, 0, 0, c1, c2);
    endtask

    task automatic test_time();
        logic c1, c2;
        repeat (2) press(0, 1, 0, 0, 0, c1, c2);
        repeat (7) press(0, 0, 1, 0, 0, c1, c2);
        vecs++; if (time_hours !== 5'd7) begin errs++; $display("FAIL hours_up7: got %0d want 7", time_hours); end
        press(0, 1, 0, 0, 0, c1, c2);
        press(0, 0, 0, 1, 0, c1, c2);
        vecs++; if (time_minutes !== 6'd59) begin errs++; $display("FAIL min_wrap_down: got %0d want 59", time_minutes); end
        press(0, 0, 1, 0, 0, c1, c2);
        vecs++; if ({time_hours, time_minutes} !== {5'd7, 6'd0}) begin errs++; $display("FAIL min_wrap_nocarry: got %0d:%0d want 7:0", time_hours, time_minutes); end
        vecs++; if (c2 !== 1'b1) begin errs++; $display("FAIL min_wrap_changed: got %0d want 1", c2); end
        press(1, 0, 0, 0, 0, c1, c2);
        repeat (8) press(0, 0, 0, 1, 0, c1, c2);
        vecs++; if (time_hours !== 5'd23) begin errs++; $display("FAIL hours_wrap_down: got %0d want 23", time_hours); end
        press(0, 1, 0, 0, 0, c1, c2);
        press(0, 0, 0, 1, 0, c1, c2);
        tick();
        vecs++; if ({time_hours, time_minutes} !== {5'd0, 6'd0}) begin errs++; $display("FAIL tick_midnight: got %0d:%0d want 0:0", time_hours, time_minutes); end
        vecs++; if (changed !== 1'b0) begin errs++; $display("FAIL tick_changed: got %0d want 0", changed); end
        tick();
        vecs++; if ({time_hours, time_minutes} !== {5'd0, 6'd1}) begin errs++; $display("FAIL tick_plain: got %0d:%0d want 0:1", time_hours, time_minutes); end
    endtask

    task automatic test_tick_collision();
        logic c1, c2;
        press(1, 0, 0, 0, 0, c1, c2);
        press(0, 0, 1, 0, 1, c1, c2);
        vecs++; if ({time_hours, time_minutes} !== {5'd1, 6'd1}) begin errs++; $display("FAIL edit_beats_tick: got %0d:%0d want 1:1", time_hours, time_minutes); end
        press(1, 0, 0, 0, 0, c1, c2);
        press(0, 0, 1, 0, 1, c1, c2);
        vecs++; if (set_hum !== 8'd51) begin errs++; $display("FAIL hum_with_tick: got %0d want 51", set_hum); end
        vecs++; if ({time_hours, time_minutes} !== {5'd1, 6'd2}) begin errs++; $display("FAIL tick_with_hum: got %0d:%0d want 1:2", time_hours, time_minutes); end
    endtask

    task automatic test_async_reset();
        logic c1, c2;
        @(negedge clk);
        #1;
        rst = 1'b1;
        btn_right = 1'b1;
        #1;
        vecs++; if ({state, set_hum, time_minutes} !== {4'd0, 8'd50, 6'd0}) begin errs++; $display("FAIL async_reset: got %0d/%0d/%0d want 0/50/0", state, set_hum, time_minutes); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        vecs++; if (state !== 4'd0) begin errs++; $display("FAIL held_through_reset: got %0d want 0", state); end
        btn_right = 1'b0;
        repeat (2) @(negedge clk);
        press(0, 1, 0, 0, 0, c1, c2);
        vecs++; if (state !== 4'd1) begin errs++; $display("FAIL press_after_held: got %0d want 1", state); end
    endtask

    task automatic test_autorepeat();
        logic [7:0] want;
`ifdef MENU_AUTOREPEAT_EN
        want = 8'd56;
`else
        want = 8'd51;
`endif
        @(negedge clk);
        btn_up = 1'b1;
        repeat (30) @(negedge clk);
        btn_up = 1'b0;
        repeat (4) @(negedge clk);
        vecs++; if (set_hum !== want) begin errs++; $display("FAIL hold_up30: got %0d want %0d", set_hum, want); end
    endtask

    initial begin
        test_reset();
        test_nav();
        test_temp_sat();
        test_time();
        test_tick_collision();
        test_async_reset();
        test_autorepeat();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
